// File: rtl/funct_sample_reader.sv
// Read-side consumer of the function generator sample FIFO: paced pops, sample hold,
// offset-binary DAC conversion and underrun tracking.
module funct_sample_reader #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned INT_BITS   = 4,
    parameter int unsigned DIV_WIDTH  = 16,
    parameter int unsigned DAC_WIDTH  = 12,
    parameter int unsigned UCNT_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en_i,
    input  logic [DIV_WIDTH-1:0]  div_i,
    input  logic                  clr_underrun_i,
    input  logic                  empty_i,
    input  logic [DATA_WIDTH-1:0] data_i,
    output logic                  rd_en_o,
    output logic [DATA_WIDTH-1:0] sample_o,
    output logic                  sample_valid_o,
    output logic [DAC_WIDTH-1:0]  dac_o,
    output logic                  underrun_o,
    output logic [UCNT_WIDTH-1:0] underrun_cnt_o
);

    localparam int unsigned FracBits = DATA_WIDTH - INT_BITS;
    localparam int unsigned Shift    = FracBits - (DAC_WIDTH - 1);

    localparam logic signed [DATA_WIDTH-1:0] DacMax =
        {{(DATA_WIDTH - DAC_WIDTH + 1){1'b0}}, {(DAC_WIDTH - 1){1'b1}}};
    localparam logic signed [DATA_WIDTH-1:0] DacMin =
        {{(DATA_WIDTH - DAC_WIDTH + 1){1'b1}}, {(DAC_WIDTH - 1){1'b0}}};
    localparam logic [DAC_WIDTH-1:0] DacMid = {1'b1, {(DAC_WIDTH - 1){1'b0}}};

    typedef enum logic [1:0] {StIdle, StPrime, StRun} state_e;

    state_e                  state_q, state_d;
    logic [DIV_WIDTH-1:0]    div_cnt_q, div_cnt_d;
    logic                    rd_pend_q;
    logic [DATA_WIDTH-1:0]   sample_q;
    logic [DAC_WIDTH-1:0]    dac_q, dac_d;
    logic                    sample_valid_q;
    logic                    underrun_q;
    logic [UCNT_WIDTH-1:0]   ucnt_q;

    logic                    active;
    logic                    tick;
    logic                    rd_en;
    logic                    underrun_evt;
    logic signed [DATA_WIDTH-1:0] shifted;
    logic signed [DATA_WIDTH-1:0] clamped;

    // Divider, FSM and pop request
    always_comb begin
        active       = (state_q != StIdle);
        tick         = active && (div_cnt_q == div_i);
        rd_en        = tick && !empty_i && en_i;
        underrun_evt = tick && empty_i && en_i && (state_q == StRun);

        // Wraps on the compare, and also when div_i shrank below the count (no tick then)
        div_cnt_d = '0;
        if (en_i && active && (div_cnt_q < div_i)) begin
            div_cnt_d = div_cnt_q + DIV_WIDTH'(1);
        end

        state_d = state_q;
        if (!en_i) begin
            state_d = StIdle;
        end else begin
            case (state_q)
                StIdle:  state_d = StPrime;
                StPrime: if (rd_en) state_d = StRun;
                StRun:   state_d = StRun;
                default: state_d = StIdle;
            endcase
        end
    end

    // Q-format to offset-binary: arithmetic shift, clamp, flip the sign bit
    always_comb begin
        shifted = $signed(data_i) >>> Shift;
        clamped = shifted;
        if (shifted > DacMax) begin
            clamped = DacMax;
        end else if (shifted < DacMin) begin
            clamped = DacMin;
        end
        dac_d = {~clamped[DAC_WIDTH-1], clamped[DAC_WIDTH-2:0]};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= StIdle;
            div_cnt_q      <= '0;
            rd_pend_q      <= 1'b0;
            sample_q       <= '0;
            dac_q          <= DacMid;
            sample_valid_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            div_cnt_q      <= div_cnt_d;
            rd_pend_q      <= rd_en;
            sample_valid_q <= rd_pend_q;
            // Data is valid the cycle after the pop, independent of en_i
            if (rd_pend_q) begin
                sample_q <= data_i;
                dac_q    <= dac_d;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            underrun_q <= 1'b0;
            ucnt_q     <= '0;
        end else if (clr_underrun_i) begin
            underrun_q <= 1'b0;
            ucnt_q     <= '0;
        end else if (underrun_evt) begin
            underrun_q <= 1'b1;
            if (ucnt_q != {UCNT_WIDTH{1'b1}}) begin
                ucnt_q <= ucnt_q + UCNT_WIDTH'(1);
            end
        end
    end

    assign rd_en_o        = rd_en;
    assign sample_o       = sample_q;
    assign sample_valid_o = sample_valid_q;
    assign dac_o          = dac_q;
    assign underrun_o     = underrun_q;
    assign underrun_cnt_o = ucnt_q;

endmodule

// File: doc/funct_sample_reader.md
Name: funct_sample_reader

Overview:
- FIFO read-side consumer for the function generator's sample stream.
- Pops fixed-point samples from the FIFO at a programmable sample rate and holds the current sample.
- Converts each sample to an offset-binary DAC code and flags FIFO underruns.
- Sits between the FIFO read port and the DAC/output stage.

Parameters:
DATA_WIDTH, 32, sample word width; signed Q(INT_BITS).(DATA_WIDTH-INT_BITS) format, same as the generator output.
INT_BITS, 4, integer bits of the sample format; F = DATA_WIDTH-INT_BITS fraction bits.
DIV_WIDTH, 16, width of the sample-rate divider.
DAC_WIDTH, 12, DAC code width; requires F >= DAC_WIDTH-1.
UCNT_WIDTH, 16, underrun counter width.

Ports:
clk  input  1  system clock, all logic on the rising edge.
rst  input  1  asynchronous reset, active-high.
en_i  input  1  stream enable, level.
div_i  input  DIV_WIDTH  sample period minus 1, in clk cycles; sampled every cycle.
clr_underrun_i  input  1  synchronous clear of underrun_o and underrun_cnt_o.
empty_i  input  1  FIFO empty flag.
data_i  input  DATA_WIDTH  FIFO read data; valid in the cycle after rd_en_o.
rd_en_o  output  1  FIFO pop request, one-cycle pulse.
sample_o  output  DATA_WIDTH  last captured signed sample, held between captures.
sample_valid_o  output  1  one-cycle pulse when sample_o and dac_o update.
dac_o  output  DAC_WIDTH  offset-binary DAC code of sample_o.
underrun_o  output  1  sticky underrun flag.
underrun_cnt_o  output  UCNT_WIDTH  saturating count of missed ticks.

Behaviour:
- Reset values: rd_en_o=0, sample_o=0, sample_valid_o=0, dac_o=2^(DAC_WIDTH-1) (midscale 0x800), underrun_o=0, underrun_cnt_o=0, FSM=IDLE, divider=0.
- Divider:
  - Counts 0..div_i while FSM is PRIME or RUN; tick when count==div_i, then wraps to 0.
  - div_i=0 gives a tick every cycle.
  - A div_i change takes effect at the next compare; if count > new div_i, the counter wraps to 0 without a tick.
  - The counter is held at 0 in IDLE.
- FSM states: IDLE, PRIME, RUN.
  - IDLE -> PRIME when en_i=1.
  - PRIME: on tick with empty_i=0, pulse rd_en_o and go to RUN. A tick with empty_i=1 is ignored; no underrun is counted.
  - RUN: on tick with empty_i=0, pulse rd_en_o. On tick with empty_i=1, no pop; set underrun_o and increment underrun_cnt_o (saturating at all-ones); sample_o is held.
  - Any state -> IDLE when en_i=0; the divider clears that cycle.
  - rd_en_o is combinational: tick & !empty_i & en_i & (state PRIME or RUN). It is never asserted in IDLE.
- Capture pipeline:
  - rd_pend register is set to rd_en_o each cycle.
  - When rd_pend=1: sample_o<=data_i, dac_o<=conv(data_i), sample_valid_o=1 for one cycle.
  - Latency: rd_en_o at cycle N -> sample_o/dac_o/sample_valid_o at cycle N+2 (data at N+1, registered at the edge ending N+1).
  - A pending capture completes even if en_i drops in cycle N+1; no popped word is lost.
  - Back-to-back pops (div_i=0) capture every cycle.
- Conversion conv(x):
  - s = x >>> (F-(DAC_WIDTH-1)), arithmetic shift with truncation.
  - Clamp s to [-2^(DAC_WIDTH-1), 2^(DAC_WIDTH-1)-1].
  - dac = s + 2^(DAC_WIDTH-1), i.e. invert the MSB.
- Underrun flags:
  - clr_underrun_i has priority over a simultaneous underrun event: the result is flag=0, count=0.
  - The flag and count persist across IDLE; only reset and clr_underrun_i clear them.
- Mid-operation reset: all outputs return to reset values immediately (async); a pending capture is discarded.

Test Plan:
- Reset, then en_i=1, div_i=3, FIFO holding 0x08000000, 0x00000000, 0xF0000000 -> rd_en_o pulses every 4 cycles; each sample appears 2 cycles after its pop; dac_o = 0xC00, 0x800, 0x000.
- Saturation: data 0x10000000 (+1.0) -> dac_o=0xFFF; data 0x7FFFFFFF -> 0xFFF; data 0x80000000 -> 0x000; data 0xFFFE0000 -> 0x7FF.
- Empty at start: en_i=1, empty_i=1 for 10 cycles, div_i=0 -> no rd_en_o, underrun_o=0 (PRIME). Then empty_i=0 -> pop; next empty tick in RUN -> underrun_o=1, underrun_cnt_o increments per tick, sample_o held.
- div_i=0 with 5 queued words -> rd_en_o high 5 consecutive cycles; sample_valid_o high 5 consecutive cycles starting 2 cycles later; all values in order.
- en_i dropped the cycle after a pop -> that word is still captured with sample_valid_o=1; no further rd_en_o; divider returns to 0.
- clr_underrun_i in the same cycle as an underrun tick -> underrun_o=0, cnt=0. Async rst asserted mid-capture -> dac_o=0x800 and sample_valid_o=0 immediately.
